dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port 1024-word data memory.
- Master 0 is the core load/store unit; master 1 is the debug/DMA port.
- Grants one transaction at a time, drives the memory's address, write-data and write-enable pins, captures read data and returns it with a one-cycle response strobe.
- Provides round-robin fairness, an atomic lock for read-modify-write sequences, and out-of-range address checking.

Parameters:
- DEPTH, 1024, number of memory words; word addresses at or above DEPTH are out of range.
- LOCK_MAX, 8, maximum number of idle cycles a lock may hold the arbiter before it is force-released.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req / m1_req  input  1  request valid; held with its fields stable until the matching gnt.
- m0_we / m1_we  input  1  1 = write, 0 = read.
- m0_lock / m1_lock  input  1  keep ownership after this transaction.
- m0_addr / m1_addr  input  32  word address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_gnt / m1_gnt  output  1  one-cycle accept pulse.
- m0_rvalid / m1_rvalid  output  1  one-cycle response strobe.
- m0_rdata / m1_rdata  output  32  read data, valid while rvalid is high.
- m0_err / m1_err  output  1  out-of-range flag, valid while rvalid is high.
- mem_A  output  32  memory address.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  32  memory read data; combinational from mem_A, forced to 0 by the memory while mem_we is high.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - All gnt, rvalid and err outputs 0; all rdata outputs 0.
  - mem_we = 0, mem_A = 0, mem_wd = 0.
  - last = 1, so master 0 wins the first tie.
  - Lock cleared; lock counter 0.
- State machine IDLE -> ACCESS -> RESP -> IDLE. One transaction per 3 cycles.
- IDLE, arbitration:
  - If the lock is held by master k, only mk_req is eligible.
  - Otherwise a single requester wins. On a tie, the master other than `last` wins.
  - The winner gets gnt = 1 for this cycle only, and its we, lock, addr and wdata are registered. `last` is set to the winner. Next state is ACCESS.
  - No request: stay in IDLE, all outputs quiet.
- ACCESS, registered outputs:
  - mem_A = registered address.
  - mem_wd = registered write data.
  - mem_we = registered we AND (address < DEPTH).
  - The write commits at the rising edge that ends ACCESS.
  - mem_rd is sampled at that same edge into the rdata register (reads only; writes capture 0).
  - Next state is RESP.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle, with rdata and err.
  - err = 1 iff address >= DEPTH. Out-of-range: read returns 0, write is suppressed (mem_we never asserts).
  - mem_we = 0.
  - Lock update: if the registered lock bit = 1, the lock is set to the owner; otherwise it is cleared. The lock counter resets to 0.
  - Next state is IDLE.
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2, next grant possible in N+3.
- Lock timeout:
  - While locked in IDLE with no request from the owner, the counter increments each cycle.
  - On reaching LOCK_MAX the lock clears at that edge, and the other master may be granted in the following cycle.
- A request asserted in ACCESS or RESP is not granted until IDLE; requesters hold req until gnt.
- Deasserting req before gnt is legal; no transaction occurs.
- Reset mid-transaction: the transaction is abandoned, no rvalid is issued, and the lock is cleared. A write is suppressed if reset asserts before the commit edge.
- Unused output fields: rdata and err of the non-owner stay 0.

Decomposition:
- Shared package:
  - State enum {IDLE, ACCESS, RESP}.
  - DMEM_DEPTH = 1024.
  - Master index constants M_CORE = 0, M_DBG = 1.
- Natural sub-module: rr_arb2. A combinational two-way round-robin pick with a lock mask, taking inputs req[1:0], last, lock_valid, lock_owner and producing a one-hot grant.
- The FSM, datapath registers and lock counter live in the top level.

Test Plan:
- Single write then read:
  - m0 write addr 5, wdata 0xDEADBEEF. Expect m0_gnt at cycle 1, mem_we = 1 with mem_A = 5 at cycle 2, m0_rvalid with m0_err = 0 at cycle 3.
  - m0 read addr 5. Expect m0_rdata = 0xDEADBEEF.
- Tie round-robin: both masters request reads continuously from reset. Grants alternate m0, m1, m0, m1, spaced 3 cycles apart; each rvalid goes only to its owner.
- Lock:
  - m1 reads addr 7 with lock = 1 while m0 requests continuously. m1's next request (write addr 7) is granted before m0.
  - With lock = 0 on that write, m0 is granted next.
- Lock timeout: m0 locks, then idles with m1 requesting. m1_gnt arrives exactly LOCK_MAX + 1 cycles after m0_rvalid.
- Out of range: m1 write addr 1024, wdata 0x1. mem_we stays 0 throughout; m1_rvalid = 1 with m1_err = 1; a subsequent read of addr 0 is unchanged.
- Reset mid-op: assert rst low during ACCESS of a m0 write to addr 3. No rvalid; all outputs 0 immediately; after release, a read of addr 3 returns its old value and m0 wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Sizes, master indices, the sequencer state type and the request payload.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DMEM_DEPTH   = 1024;
    localparam int unsigned LOCK_MAX_DEF = 8;
    localparam int unsigned NUM_M        = 2;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // Word address falls inside the physical memory.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return addr < ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports and the memory pins seen by the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_A, mem_wd, mem_we,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_A, mem_wd, mem_we,
        output mem_rd
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick with a lock mask; purely combinational.
// On a tie the master that did not win last time is chosen.
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic [1:0] gnt_c
);

    logic [1:0] elig;

    always_comb begin
        elig = req;
        if (lock_valid) begin
            elig = (lock_owner == M_DBG) ? (req & 2'b10) : (req & 2'b01);
        end
        gnt_c = elig;
        if (elig == 2'b11) begin
            gnt_c = (last == M_DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory.
// Each transaction runs IDLE (grant) -> ACCESS (pins driven) -> RESP (strobe).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = DMEM_DEPTH,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    state_e                        state_q, state_d;
    logic                          owner_q, owner_d;
    logic                          we_q, we_d;
    logic                          lock_q, lock_d;
    logic                          last_q, last_d;
    logic                          lock_vld_q, lock_vld_d;
    logic                          lock_own_q, lock_own_d;
    logic [CNT_W-1:0]              lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0]             mem_a_q, mem_a_d;
    logic [DATA_W-1:0]             mem_wd_q, mem_wd_d;
    logic                          mem_we_q, mem_we_d;
    logic [NUM_M-1:0]              rvalid_q, rvalid_d;
    logic [NUM_M-1:0]              err_q, err_d;
    logic [NUM_M-1:0][DATA_W-1:0]  rdata_q, rdata_d;

    logic [1:0]  req_vec;
    logic [1:0]  pick_c;
    logic [1:0]  gnt_c;
    logic        owner_req;
    logic        txn_in_rng;
    dmem_req_t   m0_payload, m1_payload, win_req;

    assign req_vec    = {bus.m1_req, bus.m0_req};
    assign owner_req  = (lock_own_q == M_DBG) ? bus.m1_req : bus.m0_req;
    assign txn_in_rng = in_range(mem_a_q, DEPTH);

    assign m0_payload = '{we: bus.m0_we, lock: bus.m0_lock, addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign m1_payload = '{we: bus.m1_we, lock: bus.m1_lock, addr: bus.m1_addr, wdata: bus.m1_wdata};
    assign win_req    = pick_c[M_DBG] ? m1_payload : m0_payload;

    dmem_arbiter_rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last       (last_q),
        .lock_valid (lock_vld_q),
        .lock_owner (lock_own_q),
        .gnt_c      (pick_c)
    );

    // Grant is an accept pulse in the IDLE cycle itself; held quiet while in reset.
    assign gnt_c = (state_q == IDLE && rst) ? pick_c : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= M_CORE;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            last_q     <= M_DBG;
            lock_vld_q <= 1'b0;
            lock_own_q <= M_CORE;
            lock_cnt_q <= '0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            mem_we_q   <= 1'b0;
            rvalid_q   <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lock_q     <= lock_d;
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
            mem_we_q   <= mem_we_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lock_d     = lock_q;
        last_d     = last_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        mem_a_d    = '0;
        mem_wd_d   = '0;
        mem_we_d   = 1'b0;
        rvalid_d   = '0;
        err_d      = '0;
        rdata_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_c != 2'b00) begin
                    state_d  = ACCESS;
                    owner_d  = pick_c[M_DBG];
                    last_d   = pick_c[M_DBG];
                    we_d     = win_req.we;
                    lock_d   = win_req.lock;
                    mem_a_d  = win_req.addr;
                    mem_wd_d = win_req.wdata;
                    mem_we_d = win_req.we & in_range(win_req.addr, DEPTH);
                end else if (lock_vld_q && !owner_req) begin
                    // Idle owner: force the lock open after LOCK_MAX cycles.
                    if (lock_cnt_q == CNT_LAST) begin
                        lock_vld_d = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                state_d           = RESP;
                rvalid_d[owner_q] = 1'b1;
                err_d[owner_q]    = ~txn_in_rng;
                if (!we_q && txn_in_rng) begin
                    rdata_d[owner_q] = bus.mem_rd;
                end
            end
            RESP: begin
                state_d    = IDLE;
                lock_vld_d = lock_q;
                lock_own_d = owner_q;
                lock_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m0_gnt    = gnt_c[M_CORE];
    assign bus.m1_gnt    = gnt_c[M_DBG];
    assign bus.m0_rvalid = rvalid_q[M_CORE];
    assign bus.m1_rvalid = rvalid_q[M_DBG];
    assign bus.m0_err    = err_q[M_CORE];
    assign bus.m1_err    = err_q[M_DBG];
    assign bus.m0_rdata  = rdata_q[M_CORE];
    assign bus.m1_rdata  = rdata_q[M_DBG];
    assign bus.mem_A     = mem_a_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned LOCK_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory device: initial pattern 0x1000_0000 + index, writes at the rising edge.
    logic [31:0] dev_mem [0:1023];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.mem_we && bus.mem_A < 32'(DEPTH)) begin
            dev_mem[bus.mem_A[9:0]] <= bus.mem_wd;
        end
    end
    always_comb begin
        bus.mem_rd = 32'h0;
        if (!bus.mem_we && bus.mem_A < 32'(DEPTH)) bus.mem_rd = dev_mem[bus.mem_A[9:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rst_next;

    // Requester queues
    dmem_req_t mq0[$];
    dmem_req_t mq1[$];
    int start0, start1;

    // Reference model state
    logic [31:0] ref_mem [0:1023];
    int          gcyc;
    int          m_owner;
    dmem_req_t   m_txn;
    int          m_last;
    int          m_lock;
    int          m_idle;
    logic [31:0] m_rdata_exp;
    logic        m_err_exp;

    // Observed DUT events
    int          gnt_m[$];
    int          gnt_cq[$];
    logic [31:0] rvq0[$];
    logic [31:0] rvq1[$];
    int          rv_cyc[2];
    logic [1:0]  rv_err;
    int          we_count;
    int          we_cyc;
    logic [31:0] we_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [31:0] dget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic dmem_req_t mk(input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
        return '{we: we, lock: lk, addr: a, wdata: d};
    endfunction

    task automatic model_reset();
        gcyc   = -100;
        m_last = 1;
        m_lock = -1;
        m_idle = 0;
    endtask

    task automatic clear_logs();
        gnt_m.delete(); gnt_cq.delete(); rvq0.delete(); rvq1.delete();
        rv_cyc[0] = -1; rv_cyc[1] = -1; rv_err = 2'b00;
        we_count = 0; we_cyc = -1; we_addr = '1;
    endtask

    task automatic drive();
        rst = rst_next;
        if (mq0.size() > 0 && cyc >= start0) begin
            bus.m0_req = 1'b1; bus.m0_we = mq0[0].we; bus.m0_lock = mq0[0].lock;
            bus.m0_addr = mq0[0].addr; bus.m0_wdata = mq0[0].wdata;
        end else begin
            bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_lock = 1'b0;
            bus.m0_addr = '0; bus.m0_wdata = '0;
        end
        if (mq1.size() > 0 && cyc >= start1) begin
            bus.m1_req = 1'b1; bus.m1_we = mq1[0].we; bus.m1_lock = mq1[0].lock;
            bus.m1_addr = mq1[0].addr; bus.m1_wdata = mq1[0].wdata;
        end else begin
            bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0;
            bus.m1_addr = '0; bus.m1_wdata = '0;
        end
    endtask

    // Compare every DUT output with the model, log events, then advance the model.
    task automatic compare_and_step();
        int win;
        bit freec, acc, rsp, e0, e1;
        logic [1:0]  xg, xrv, xerr;
        logic [31:0] xa, xwd, xrd0, xrd1;
        logic        xwe;
        win = -1; xg = '0; xrv = '0; xerr = '0; xa = '0; xwd = '0; xrd0 = '0; xrd1 = '0; xwe = 1'b0;
        freec = 0; acc = 0; rsp = 0;
        if (rst) begin
            freec = (cyc >= gcyc + 3);
            acc   = (cyc == gcyc + 1);
            rsp   = (cyc == gcyc + 2);
            if (freec) begin
                e0 = bus.m0_req && (m_lock < 0 || m_lock == 0);
                e1 = bus.m1_req && (m_lock < 0 || m_lock == 1);
                if (e0 && e1) win = (m_last == 1) ? 0 : 1;
                else if (e0)  win = 0;
                else if (e1)  win = 1;
            end
            if (win >= 0) xg[win] = 1'b1;
            if (acc) begin
                xa = m_txn.addr; xwd = m_txn.wdata;
                xwe = m_txn.we && (m_txn.addr < 32'(DEPTH));
            end
            if (rsp) begin
                xrv[m_owner] = 1'b1;
                xerr[m_owner] = m_err_exp;
                if (m_owner == 0) xrd0 = m_rdata_exp; else xrd1 = m_rdata_exp;
            end
        end
        check("m0_gnt", bus.m0_gnt, xg[0]);
        check("m1_gnt", bus.m1_gnt, xg[1]);
        check("mem_A", bus.mem_A, xa);
        check("mem_wd", bus.mem_wd, xwd);
        check("mem_we", bus.mem_we, xwe);
        check("m0_rvalid", bus.m0_rvalid, xrv[0]);
        check("m1_rvalid", bus.m1_rvalid, xrv[1]);
        check("m0_err", bus.m0_err, xerr[0]);
        check("m1_err", bus.m1_err, xerr[1]);
        check("m0_rdata", bus.m0_rdata, xrd0);
        check("m1_rdata", bus.m1_rdata, xrd1);

        if (bus.m0_gnt) begin gnt_m.push_back(0); gnt_cq.push_back(cyc); end
        if (bus.m1_gnt) begin gnt_m.push_back(1); gnt_cq.push_back(cyc); end
        if (bus.mem_we) begin we_count++; we_cyc = cyc; we_addr = bus.mem_A; end
        if (bus.m0_rvalid) begin rvq0.push_back(bus.m0_rdata); rv_cyc[0] = cyc; rv_err[0] = bus.m0_err; end
        if (bus.m1_rvalid) begin rvq1.push_back(bus.m1_rdata); rv_cyc[1] = cyc; rv_err[1] = bus.m1_err; end

        if (!rst) begin
            model_reset();
        end else begin
            if (win >= 0) begin
                gcyc = cyc; m_owner = win; m_last = win;
                if (win == 0) m_txn = mq0.pop_front(); else m_txn = mq1.pop_front();
            end
            if (acc) begin
                m_err_exp   = !(m_txn.addr < 32'(DEPTH));
                m_rdata_exp = (!m_txn.we && !m_err_exp) ? ref_mem[m_txn.addr[9:0]] : 32'h0;
                if (m_txn.we && !m_err_exp) ref_mem[m_txn.addr[9:0]] = m_txn.wdata;
            end
            if (rsp) begin
                m_lock = m_txn.lock ? m_owner : -1;
                m_idle = 0;
            end
            if (freec && win < 0 && m_lock >= 0 &&
                !((m_lock == 0) ? bus.m0_req : bus.m1_req)) begin
                m_idle++;
                if (m_idle == int'(LOCK_MAX)) begin m_lock = -1; m_idle = 0; end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        compare_and_step();
    endtask

    task automatic run_until_idle(input string name);
        int n;
        n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || cyc < gcyc + 3) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset();
        rst_next = 1'b0;
        cycle();
        rst_next = 1'b1;
    endtask

    int p;

    initial begin
        rst = 1'b0; rst_next = 1'b0; mem_init = 1'b1;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        m_txn = '0; m_owner = 0; m_rdata_exp = '0; m_err_exp = 1'b0;
        start0 = 0; start1 = 0;
        model_reset();
        clear_logs();

        // Reset state
        cycle();
        cycle();
        mem_init = 1'b0;
        rst_next = 1'b1;

        // Single write then read
        clear_logs();
        p = cyc + 1;
        start0 = p;
        mq0.push_back(mk(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF));
        run_until_idle("t1");
        check("t1_gnt_cycle", qget(gnt_cq, 0), p);
        check("t1_we_cycle", we_cyc, p + 1);
        check("t1_we_addr", we_addr, 32'd5);
        check("t1_rvalid_cycle", rv_cyc[0], p + 2);
        check("t1_err", rv_err[0], 1'b0);
        clear_logs();
        start0 = cyc + 1;
        mq0.push_back(mk(1'b0, 1'b0, 32'd5, 32'h0));
        run_until_idle("t1r");
        check("t1_rdata", dget(rvq0, 0), 32'hDEAD_BEEF);

        // Round-robin tie from reset
        do_reset();
        clear_logs();
        start0 = cyc + 1; start1 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            mq0.push_back(mk(1'b0, 1'b0, 32'(10 + i), 32'h0));
            mq1.push_back(mk(1'b0, 1'b0, 32'(20 + i), 32'h0));
        end
        run_until_idle("t2");
        for (int i = 0; i < 4; i++) check("t2_order", qget(gnt_m, i), i % 2);
        for (int i = 0; i < 3; i++) check("t2_spacing", qget(gnt_cq, i + 1) - qget(gnt_cq, i), 3);
        check("t2_m0_rvalids", rvq0.size(), 4);
        check("t2_m1_rvalids", rvq1.size(), 4);
        check("t2_m1_first_data", dget(rvq1, 0), 32'h1000_0014);

        // Lock held by m1 across a read-modify-write
        clear_logs();
        start1 = cyc + 1; start0 = cyc + 2;
        mq1.push_back(mk(1'b0, 1'b1, 32'd7, 32'h0));
        mq1.push_back(mk(1'b1, 1'b0, 32'd7, 32'h0000_0077));
        mq0.push_back(mk(1'b0, 1'b0, 32'd7, 32'h0));
        run_until_idle("t3");
        check("t3_g0", qget(gnt_m, 0), 1);
        check("t3_g1", qget(gnt_m, 1), 1);
        check("t3_g2", qget(gnt_m, 2), 0);
        check("t3_m1_read", dget(rvq1, 0), 32'h1000_0007);
        check("t3_m0_read", dget(rvq0, 0), 32'h0000_0077);

        // Lock timeout
        clear_logs();
        start0 = cyc + 1; start1 = cyc + 2;
        mq0.push_back(mk(1'b0, 1'b1, 32'd9, 32'h0));
        mq1.push_back(mk(1'b0, 1'b0, 32'd10, 32'h0));
        run_until_idle("t4");
        check("t4_order", qget(gnt_m, 1), 1);
        check("t4_timeout_gap", qget(gnt_cq, 1) - rv_cyc[0], int'(LOCK_MAX) + 1);

        // Out-of-range write
        clear_logs();
        start1 = cyc + 1; start0 = cyc + 3;
        mq1.push_back(mk(1'b1, 1'b0, 32'd1024, 32'h1));
        mq0.push_back(mk(1'b0, 1'b0, 32'd0, 32'h0));
        run_until_idle("t5");
        check("t5_no_we", we_count, 0);
        check("t5_err", rv_err[1], 1'b1);
        check("t5_rdata_zero", dget(rvq1, 0), 32'h0);
        check("t5_addr0", dget(rvq0, 0), 32'h1000_0000);

        // Reset during ACCESS of a write
        clear_logs();
        start0 = cyc + 1;
        mq0.push_back(mk(1'b1, 1'b0, 32'd3, 32'h3333_3333));
        for (int i = 0; i < 20 && gnt_m.size() == 0; i++) cycle();
        check("t6_gnt_seen", gnt_m.size(), 1);
        rst_next = 1'b0;
        cycle();
        check("t6_we_low", bus.mem_we, 1'b0);
        cycle();
        rst_next = 1'b1;
        repeat (4) cycle();
        check("t6_no_rvalid", rvq0.size(), 0);
        clear_logs();
        start0 = cyc + 1; start1 = cyc + 1;
        mq0.push_back(mk(1'b0, 1'b0, 32'd3, 32'h0));
        mq1.push_back(mk(1'b0, 1'b0, 32'd4, 32'h0));
        run_until_idle("t6");
        check("t6_first_tie", qget(gnt_m, 0), 0);
        check("t6_addr3", dget(rvq0, 0), 32'h1000_0003);
        check("t6_addr4", dget(rvq1, 0), 32'h1000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
